fetch_stage: RTL

Instruction-fetch stage of the five-stage pipeline, directly upstream of the decode/control unit. Holds the PC, runs the instruction-cache request/response handshake, and loads the IF/ID register (instruction + PC) consumed by `control`. Raises `block_pipe_instr_cache` on misses, honours data-cache stalls, and applies branch redirects with a miss-drain state machine.

---
 rtl/fetch_stage_pkg.sv | 21 ++
 rtl/fetch_stage_if.sv | 24 ++
 rtl/fetch_hold_buf.sv | 56 +++++
 rtl/fetch_stage.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage:
// fetch FSM states, default NOP word, PC increment and the IF/ID record.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_FETCH     = 2'd0,
        ST_MISS_WAIT = 2'd1,
        ST_DRAIN     = 2'd2,
        ST_HOLD      = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP           = 32'd4;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-cache request/response bundle between the fetch stage
// (master) and the instruction cache (slave).
interface fetch_stage_if;

    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_ready;
    logic [31:0] ic_data;

    modport master (
        output ic_req,
        output ic_addr,
        input  ic_ready,
        input  ic_data
    );

    modport slave (
        input  ic_req,
        input  ic_addr,
        output ic_ready,
        output ic_data
    );

endinterface

// File: rtl/fetch_hold_buf.sv
// Single-entry skid buffer that parks a fetched word and its PC while
// the pipeline is not accepting new instructions. Flush wins over load,
// load wins over drain.
module fetch_hold_buf (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        drain,
    input  logic        flush,
    input  logic [31:0] data_in,
    input  logic [31:0] pc_in,
    output logic [31:0] data_out,
    output logic [31:0] pc_out,
    output logic        full
);

    logic [31:0] data_q, data_d;
    logic [31:0] pc_q, pc_d;
    logic        full_q, full_d;

    // Next buffer contents from the flush/load/drain controls.
    always_comb begin
        data_d = data_q;
        pc_d   = pc_q;
        full_d = full_q;
        if (flush) begin
            data_d = '0;
            pc_d   = '0;
            full_d = 1'b0;
        end else if (load) begin
            data_d = data_in;
            pc_d   = pc_in;
            full_d = 1'b1;
        end else if (drain) begin
            full_d = 1'b0;
        end
    end

    // Buffer registers, cleared on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            pc_q   <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            pc_q   <= pc_d;
            full_q <= full_d;
        end
    end

    assign data_out = data_q;
    assign pc_out   = pc_q;
    assign full     = full_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, I-cache handshake, IF/ID register,
// branch redirect with miss drain. Optional performance counters are
// built when FETCH_PERF_CNT_EN is defined; otherwise the counter ports
// read as zero.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          EN_REG_FETCH,
    input  logic          block_pipe_data_cache,
    input  logic          branch_taken,
    input  logic [31:0]   branch_target,
    fetch_stage_if.master ic,
    output logic          block_pipe_instr_cache,
    output logic [31:0]   instruction,
    output logic [31:0]   pc_out,
    output logic          valid,
    output logic [31:0]   fetch_count,
    output logic [31:0]   miss_cycles
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  redirect_pc_q, redirect_pc_d;
    if_id_t       if_id_q, if_id_d;

    logic         redirect;
    logic         buf_load, buf_drain, buf_flush;
    logic [31:0]  buf_data, buf_pc;
    logic         buf_full;

    fetch_hold_buf u_hold_buf (
        .clk      (clk),
        .reset    (reset),
        .load     (buf_load),
        .drain    (buf_drain),
        .flush    (buf_flush),
        .data_in  (ic.ic_data),
        .pc_in    (pc_q),
        .data_out (buf_data),
        .pc_out   (buf_pc),
        .full     (buf_full)
    );

    assign redirect = branch_taken && !block_pipe_data_cache;

    // Request and stall depend only on state and ic_ready, never on the enable.
    always_comb begin
        ic.ic_req              = !reset && (state_q != ST_HOLD);
        ic.ic_addr             = pc_q;
        block_pipe_instr_cache = !reset && (state_q != ST_HOLD) && !ic.ic_ready;
    end

    // Next state, PC, redirect target and IF/ID contents; an accepted redirect overrides everything.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        redirect_pc_d = redirect_pc_q;
        if_id_d       = if_id_q;
        buf_load      = 1'b0;
        buf_drain     = 1'b0;
        buf_flush     = 1'b0;
        if (redirect) begin
            if_id_d   = '{instruction: NOP_INSTR, pc: 32'h0, valid: 1'b0};
            buf_flush = 1'b1;
            if (((state_q == ST_MISS_WAIT) || (state_q == ST_DRAIN)) && !ic.ic_ready) begin
                redirect_pc_d = branch_target;
                state_d       = ST_DRAIN;
            end else begin
                pc_d    = branch_target;
                state_d = ST_FETCH;
            end
        end else begin
            unique case (state_q)
                ST_FETCH, ST_MISS_WAIT: begin
                    if (ic.ic_ready) begin
                        if (EN_REG_FETCH) begin
                            if_id_d = '{instruction: ic.ic_data, pc: pc_q, valid: 1'b1};
                            pc_d    = pc_q + PC_STEP;
                            state_d = ST_FETCH;
                        end else begin
                            buf_load = 1'b1;
                            state_d  = ST_HOLD;
                        end
                    end else begin
                        state_d = ST_MISS_WAIT;
                    end
                end
                ST_DRAIN: begin
                    if (ic.ic_ready) begin
                        pc_d    = redirect_pc_q;
                        state_d = ST_FETCH;
                    end
                end
                ST_HOLD: begin
                    if (EN_REG_FETCH) begin
                        if_id_d   = '{instruction: buf_data, pc: buf_pc, valid: buf_full};
                        pc_d      = pc_q + PC_STEP;
                        buf_drain = 1'b1;
                        state_d   = ST_FETCH;
                    end
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    // Stage registers with asynchronous reset to the power-on fetch point.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            redirect_pc_q <= '0;
            if_id_q       <= '{instruction: NOP_INSTR, pc: 32'h0, valid: 1'b0};
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            redirect_pc_q <= redirect_pc_d;
            if_id_q       <= if_id_d;
        end
    end

    assign instruction = if_id_q.instruction;
    assign pc_out      = if_id_q.pc;
    assign valid       = if_id_q.valid;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] miss_cycles_q, miss_cycles_d;
    logic        count_load;

    // Count valid IF/ID loads and instruction-side stall cycles; both wrap at 2^32.
    always_comb begin
        count_load = !redirect && EN_REG_FETCH &&
                     ((((state_q == ST_FETCH) || (state_q == ST_MISS_WAIT)) && ic.ic_ready) ||
                      ((state_q == ST_HOLD) && buf_full));
        fetch_count_d = fetch_count_q + {31'd0, count_load};
        miss_cycles_d = miss_cycles_q + {31'd0, block_pipe_instr_cache};
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count_q <= '0;
            miss_cycles_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            miss_cycles_q <= miss_cycles_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign miss_cycles = miss_cycles_q;
`else
    assign fetch_count = '0;
    assign miss_cycles = '0;
`endif

endmodule
